// File: rtl/execute_stage.sv
// execute_stage: 32-bit ALU execute stage with registered outputs to the
// memory stage. Single-cycle ops (ADD/SUB/AND/OR/XOR/SLL/SRL/SLT) produce a
// result one edge after issue. A multi-cycle shift-add multiplier is compiled
// in only when the macro EXE_MUL_EN is defined. With the macro undefined,
// opcode 8 is treated as illegal and exe_stall is tied low.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        DX_valid,
    input  logic [3:0]  DX_op,
    input  logic [31:0] DX_A,
    input  logic [31:0] DX_B,
    input  logic [31:0] DX_imm,
    input  logic        DX_use_imm,
    input  logic [4:0]  DX_RD,
    input  logic [2:0]  DX_MW,
    input  logic [2:0]  DX_MR,
    input  logic [31:0] DX_sw_data,
    output logic [31:0] ALUout,
    output logic [4:0]  XM_RD,
    output logic [2:0]  EXE_MW,
    output logic [2:0]  EXE_MR,
    output logic [31:0] EXE_sw_data,
    output logic        exe_stall
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
`ifdef EXE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
`endif

    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        mul_done;
    logic [31:0] mul_result;

    assign op_b = DX_use_imm ? DX_imm : DX_B;

    // Single-cycle ALU; MUL and illegal opcodes fall through to zero.
    always_comb begin
        // NOTE: default assigned first so every path drives alu_result and no latch is inferred.
        alu_result = '0;
        case (DX_op)
            OP_ADD:  alu_result = DX_A + op_b;
            OP_SUB:  alu_result = DX_A - op_b;
            OP_AND:  alu_result = DX_A & op_b;
            OP_OR:   alu_result = DX_A | op_b;
            OP_XOR:  alu_result = DX_A ^ op_b;
            OP_SLL:  alu_result = DX_A << op_b[4:0];
            OP_SRL:  alu_result = DX_A >> op_b[4:0];
            OP_SLT:  alu_result = {31'b0, $signed(DX_A) < $signed(op_b)};
            default: alu_result = '0;
        endcase
    end

`ifdef EXE_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    mul_state_e  state;
    mul_state_e  state_next;
    logic [31:0] mul_mcand;
    logic [31:0] mul_mplier;
    logic [31:0] mul_prod;
    logic [4:0]  mul_cnt;
    logic        mul_issue;

    assign mul_issue  = DX_valid && (DX_op == OP_MUL);
    assign mul_done   = (state == DONE);
    assign mul_result = mul_prod;

    // Multiplier FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and stall: the instruction is held upstream from issue through the last BUSY cycle.
    always_comb begin
        state_next = state;
        exe_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (mul_issue) begin
                    exe_stall  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                exe_stall = 1'b1;
                if (mul_cnt == 5'd31) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift-add datapath: operands latched at issue, one partial product per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and counter registers are reset so an abandoned multiply leaves no residue.
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_prod   <= '0;
            mul_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_issue) begin
                        mul_mcand  <= DX_A;
                        mul_mplier <= op_b;
                        mul_prod   <= '0;
                        mul_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (mul_mplier[0]) mul_prod <= mul_prod + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
`else
    assign exe_stall  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // Output register: bubble while stalled or invalid, product on the DONE edge, else ALU result.
    always_ff @(posedge clk) begin
        if (rst || exe_stall || (!DX_valid && !mul_done)) begin
            ALUout      <= '0;
            XM_RD       <= '0;
            EXE_MW      <= '0;
            EXE_MR      <= '0;
            EXE_sw_data <= '0;
        end else begin
            ALUout      <= mul_done ? mul_result : alu_result;
            XM_RD       <= DX_RD;
            EXE_MW      <= DX_MW;
            EXE_MR      <= DX_MR;
            EXE_sw_data <= DX_sw_data;
        end
    end

endmodule
